// File: rtl/match_pkg.sv
// Shared types and default parameters for the two-player match sequencer.
//   state_t  : sequencer FSM states
//   winner_t : side encoding used for the latched round winner and match winner
package match_pkg;

  localparam int unsigned SCORE_W_DEF      = 3;
  localparam int unsigned WIN_SCORE_DEF    = 7;
  localparam int unsigned PAUSE_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    CLEAR,
    PAUSE,
    PLAY,
    AWARD,
    OVER
  } state_t;

  typedef enum logic [1:0] {
    W_NONE  = 2'b00,
    W_LEFT  = 2'b01,
    W_RIGHT = 2'b10
  } winner_t;

endpackage

// File: rtl/pause_timer.sv
// Load/decrement down-counter timing the between-round pause.
//   clk, reset  : clock, synchronous active-high reset (counter cleared, done set)
//   load_i      : load counter with load_val_i (has priority over dec_i)
//   load_val_i  : reload value
//   dec_i       : decrement by one while non-zero
//   done_o      : registered flag, high while the counter reads zero
module pause_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q;

  // Next count: load wins, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == '0);
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/match_sequencer.sv
// Two-player match sequencer: turns playfield round wins into single-cycle
// score-counter increments, pauses the playfield between rounds and ends the
// match when a side reaches WIN_SCORE.
//   clk, reset             : clock, synchronous active-high reset
//   left_win, right_win    : round-win levels from the playfield
//   new_match              : start a new match (only acted on in OVER)
//   count_left/right       : one-cycle increment pulses to the score counters
//   score_reset            : clears both score counters
//   field_reset            : holds the playfield in reset
//   match_over             : high while the match is decided
//   winner                 : 00 none, 01 left, 10 right (non-zero only in OVER)
module match_sequencer
  import match_pkg::*;
#(
  parameter int unsigned SCORE_W      = SCORE_W_DEF,
  parameter int unsigned WIN_SCORE    = WIN_SCORE_DEF,
  parameter int unsigned PAUSE_CYCLES = PAUSE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_win,
  input  logic       right_win,
  input  logic       new_match,
  output logic       count_left,
  output logic       count_right,
  output logic       score_reset,
  output logic       field_reset,
  output logic       match_over,
  output logic [1:0] winner
);

  localparam int unsigned CNT_W = $clog2(PAUSE_CYCLES + 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   RELOAD    = CNT_W'(PAUSE_CYCLES - 1);

  state_t               state_q, state_d;
  winner_t              side_q, side_d;
  winner_t              winner_q, winner_d;
  logic [SCORE_W-1:0]   score_l_q, score_l_d;
  logic [SCORE_W-1:0]   score_r_q, score_r_d;
  logic [SCORE_W-1:0]   cur_score, inc_score;
  logic                 tmr_load, tmr_dec, tmr_done;

  logic count_left_q, count_left_d;
  logic count_right_q, count_right_d;
  logic score_reset_q, score_reset_d;
  logic field_reset_q, field_reset_d;
  logic match_over_q, match_over_d;

  pause_timer #(
    .W (CNT_W)
  ) u_pause_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (RELOAD),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  // Next-state, shadow score and timer control.
  always_comb begin
    state_d   = state_q;
    side_d    = side_q;
    winner_d  = winner_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    cur_score = (side_q == W_LEFT) ? score_l_q : score_r_q;
    inc_score = (cur_score >= WIN_VAL) ? WIN_VAL : cur_score + SCORE_W'(1);

    unique case (state_q)
      CLEAR: begin
        score_l_d = '0;
        score_r_d = '0;
        side_d    = W_NONE;
        winner_d  = W_NONE;
        tmr_load  = 1'b1;
        state_d   = PAUSE;
      end
      PAUSE: begin
        if (tmr_done) begin
          state_d = PLAY;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      PLAY: begin
        if (left_win && right_win) begin
          // Tie: replay the round without awarding a point.
          tmr_load = 1'b1;
          state_d  = PAUSE;
        end else if (left_win || right_win) begin
          side_d  = left_win ? W_LEFT : W_RIGHT;
          state_d = AWARD;
        end
      end
      AWARD: begin
        if (side_q == W_LEFT) begin
          score_l_d = inc_score;
        end else if (side_q == W_RIGHT) begin
          score_r_d = inc_score;
        end
        if (inc_score == WIN_VAL) begin
          winner_d = side_q;
          state_d  = OVER;
        end else begin
          tmr_load = 1'b1;
          state_d  = PAUSE;
        end
      end
      OVER: begin
        if (new_match) begin
          winner_d = W_NONE;
          state_d  = CLEAR;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    count_left_d  = (state_d == AWARD) && (side_d == W_LEFT);
    count_right_d = (state_d == AWARD) && (side_d == W_RIGHT);
    score_reset_d = (state_d == CLEAR);
    field_reset_d = (state_d != PLAY);
    match_over_d  = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CLEAR;
      side_q        <= W_NONE;
      winner_q      <= W_NONE;
      score_l_q     <= '0;
      score_r_q     <= '0;
      count_left_q  <= 1'b0;
      count_right_q <= 1'b0;
      score_reset_q <= 1'b1;
      field_reset_q <= 1'b1;
      match_over_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      side_q        <= side_d;
      winner_q      <= winner_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      count_left_q  <= count_left_d;
      count_right_q <= count_right_d;
      score_reset_q <= score_reset_d;
      field_reset_q <= field_reset_d;
      match_over_q  <= match_over_d;
    end
  end

  assign count_left  = count_left_q;
  assign count_right = count_right_q;
  assign score_reset = score_reset_q;
  assign field_reset = field_reset_q;
  assign match_over  = match_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer. Output vector layout:
// {count_left, count_right, score_reset, field_reset, match_over, winner[1:0]}
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       left_win = 1'b0;
  logic       right_win = 1'b0;
  logic       new_match = 1'b0;
  logic       count_left, count_right, score_reset, field_reset, match_over;
  logic [1:0] winner;
  logic [6:0] obs;

  int checks = 0;
  int passed = 0;

  localparam logic [6:0] V_CLR   = 7'b0011000;
  localparam logic [6:0] V_PAU   = 7'b0001000;
  localparam logic [6:0] V_PLY   = 7'b0000000;
  localparam logic [6:0] V_AWL   = 7'b1001000;
  localparam logic [6:0] V_AWR   = 7'b0101000;
  localparam logic [6:0] V_OVR_R = 7'b0001110;

  match_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .left_win    (left_win),
    .right_win   (right_win),
    .new_match   (new_match),
    .count_left  (count_left),
    .count_right (count_right),
    .score_reset (score_reset),
    .field_reset (field_reset),
    .match_over  (match_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  assign obs = {count_left, count_right, score_reset, field_reset, match_over, winner};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== V_CLR) $display("FAIL reset_hold[%0d]: got %b exp %b", i, obs, V_CLR);
      else passed++;
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== V_PAU) $display("FAIL reset_pause[%0d]: got %b exp %b", i, obs, V_PAU);
      else passed++;
    end
    tick();
    checks++;
    if (obs !== V_PLY) $display("FAIL reset_play: got %b exp %b", obs, V_PLY);
    else passed++;
  endtask

  task automatic test_left_win();
    left_win = 1'b1;
    tick();
    left_win = 1'b0;
    checks++;
    if (obs !== V_AWL) $display("FAIL left_award: got %b exp %b", obs, V_AWL);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== V_PAU) $display("FAIL left_pause[%0d]: got %b exp %b", i, obs, V_PAU);
      else passed++;
    end
    tick();
    checks++;
    if (obs !== V_PLY) $display("FAIL left_play: got %b exp %b", obs, V_PLY);
    else passed++;
    checks++;
    if (dut.score_l_q !== 3'd1) $display("FAIL left_score: got %0d exp 1", dut.score_l_q);
    else passed++;
  endtask

  task automatic test_tie();
    left_win  = 1'b1;
    right_win = 1'b1;
    tick();
    left_win  = 1'b0;
    right_win = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== V_PAU) $display("FAIL tie_pause[%0d]: got %b exp %b", i, obs, V_PAU);
      else passed++;
      tick();
    end
    checks++;
    if (obs !== V_PLY) $display("FAIL tie_play: got %b exp %b", obs, V_PLY);
    else passed++;
    checks++;
    if ({dut.score_l_q, dut.score_r_q} !== {3'd1, 3'd0})
      $display("FAIL tie_scores: got l=%0d r=%0d exp l=1 r=0", dut.score_l_q, dut.score_r_q);
    else passed++;
  endtask

  task automatic test_match_right();
    logic [8:0] rounds;
    int exp_l;
    int exp_r;
    logic [6:0] exp_v;
    // 1 = right win; consumed LSB first: R R L R R L R R R
    rounds = 9'b111011011;
    exp_l  = 1;
    exp_r  = 0;
    for (int k = 0; k < 9; k++) begin
      if (rounds[k]) begin
        right_win = 1'b1;
        exp_r++;
        exp_v = V_AWR;
      end else begin
        left_win = 1'b1;
        exp_l++;
        exp_v = V_AWL;
      end
      tick();
      left_win  = 1'b0;
      right_win = 1'b0;
      checks++;
      if (obs !== exp_v) $display("FAIL match_award[%0d]: got %b exp %b", k, obs, exp_v);
      else passed++;
      if (exp_r == 7) break;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (obs !== V_PLY) $display("FAIL match_play[%0d]: got %b exp %b", k, obs, V_PLY);
      else passed++;
    end
    tick();
    checks++;
    if (obs !== V_OVR_R) $display("FAIL match_over: got %b exp %b", obs, V_OVR_R);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      right_win = 1'b1;
      left_win  = (i == 1);
      tick();
      checks++;
      if (obs !== V_OVR_R) $display("FAIL over_ignore[%0d]: got %b exp %b", i, obs, V_OVR_R);
      else passed++;
    end
    right_win = 1'b0;
    left_win  = 1'b0;
    checks++;
    if ({dut.score_l_q, dut.score_r_q} !== {3'(exp_l), 3'(exp_r)})
      $display("FAIL match_scores: got l=%0d r=%0d exp l=%0d r=%0d",
               dut.score_l_q, dut.score_r_q, exp_l, exp_r);
    else passed++;
  endtask

  task automatic test_new_match();
    new_match = 1'b1;
    tick();
    new_match = 1'b0;
    checks++;
    if (obs !== V_CLR) $display("FAIL new_clear: got %b exp %b", obs, V_CLR);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== V_PAU) $display("FAIL new_pause[%0d]: got %b exp %b", i, obs, V_PAU);
      else passed++;
    end
    tick();
    checks++;
    if (obs !== V_PLY) $display("FAIL new_play: got %b exp %b", obs, V_PLY);
    else passed++;
    left_win = 1'b1;
    tick();
    left_win = 1'b0;
    checks++;
    if (obs !== V_AWL) $display("FAIL new_award: got %b exp %b", obs, V_AWL);
    else passed++;
    tick();
    checks++;
    if ({dut.score_l_q, dut.score_r_q} !== {3'd1, 3'd0})
      $display("FAIL new_scores: got l=%0d r=%0d exp l=1 r=0", dut.score_l_q, dut.score_r_q);
    else passed++;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (obs !== V_PLY) $display("FAIL new_replay: got %b exp %b", obs, V_PLY);
    else passed++;
  endtask

  task automatic test_reset_in_award();
    right_win = 1'b1;
    tick();
    right_win = 1'b0;
    checks++;
    if (obs !== V_AWR) $display("FAIL rst_award: got %b exp %b", obs, V_AWR);
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs !== V_CLR) $display("FAIL rst_clear: got %b exp %b", obs, V_CLR);
    else passed++;
    checks++;
    if ({dut.score_l_q, dut.score_r_q} !== {3'd0, 3'd0})
      $display("FAIL rst_scores: got l=%0d r=%0d exp l=0 r=0", dut.score_l_q, dut.score_r_q);
    else passed++;
    tick();
    checks++;
    if (obs !== V_PAU) $display("FAIL rst_pause: got %b exp %b", obs, V_PAU);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_left_win();
    test_tie();
    test_match_right();
    test_new_match();
    test_reset_in_award();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
